// File: rtl/csr_bank.sv
// Parametrised control/status register bank: masked CTRL registers, W1C STATUS with
// hardware set, IRQ enable and level interrupt. Optional CTRL lock via CSR_BANK_LOCK_EN.
module csr_bank #(
    parameter int                       NUM_RW      = 4,
    parameter int                       DATA_W      = 32,
    parameter int                       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]        BASE_ADDR   = '0,
    parameter logic [NUM_RW*DATA_W-1:0] RW_MASK     = {NUM_RW{32'hFFFF_FFFF}},
    parameter logic [NUM_RW*DATA_W-1:0] RW_RESET    = '0,
    parameter logic [DATA_W-1:0]        STATUS_MASK = 32'hFFFF_FFFF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_write,
    input  logic                       i_read,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_rvalid,
    output logic                       o_err,
    output logic [NUM_RW*DATA_W-1:0]   o_ctrl,
    input  logic [DATA_W-1:0]          i_hw_set,
    output logic [DATA_W-1:0]          o_status,
    output logic                       o_irq
);

    localparam int IDX_W = ADDR_W - 2;
`ifdef CSR_BANK_LOCK_EN
    localparam int NUM_REGS = NUM_RW + 3;
    localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'(NUM_RW + 2);
`else
    localparam int NUM_REGS = NUM_RW + 2;
`endif
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_RW);
    localparam logic [IDX_W-1:0] IRQ_EN_IDX = IDX_W'(NUM_RW + 1);
    localparam logic [IDX_W-1:0] END_IDX    = IDX_W'(NUM_REGS);

    logic [NUM_RW*DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0]        status_q;
    logic [DATA_W-1:0]        irq_en_q;
    logic [DATA_W-1:0]        status_next;
    logic [DATA_W-1:0]        irq_en_next;
    logic [DATA_W-1:0]        w1c;
    logic [DATA_W-1:0]        rd_mux;
    logic [NUM_RW-1:0]        ctrl_we;
    logic [IDX_W-1:0]         word_idx;
    logic                     mapped;
    logic                     is_ctrl;
    logic                     is_status;
    logic                     is_irq_en;
    logic                     ctrl_blocked;
    logic                     wr_ok;
    logic                     wr_hit;

    // Word index relative to the base; addresses below the base wrap high and fall outside the map.
    assign word_idx  = i_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign mapped    = (i_addr[1:0] == 2'b00) && (word_idx < END_IDX);
    assign is_ctrl   = word_idx < IDX_W'(NUM_RW);
    assign is_status = word_idx == STATUS_IDX;
    assign is_irq_en = word_idx == IRQ_EN_IDX;

`ifdef CSR_BANK_LOCK_EN
    logic lock_q;
    logic is_lock;

    assign is_lock      = word_idx == LOCK_IDX;
    assign ctrl_blocked = lock_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_q <= 1'b0;
        end else if (wr_hit && is_lock && i_wdata[0]) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign ctrl_blocked = 1'b0;
`endif

    assign wr_ok  = mapped && !(is_ctrl && ctrl_blocked);
    assign wr_hit = i_write && wr_ok;

    always_comb begin
        ctrl_we = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            ctrl_we[k] = wr_hit && is_ctrl && (word_idx == IDX_W'(k));
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_ctrl) begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (word_idx == IDX_W'(k)) begin
                    rd_mux = ctrl_q[k*DATA_W +: DATA_W];
                end
            end
        end else if (is_status) begin
            rd_mux = status_q;
        end else if (is_irq_en) begin
            rd_mux = irq_en_q;
        end
`ifdef CSR_BANK_LOCK_EN
        else if (is_lock) begin
            rd_mux = {{(DATA_W-1){1'b0}}, lock_q};
        end
`endif
    end

    // Set is OR-ed in after the clear so a concurrent hardware event is never lost.
    assign w1c         = (wr_hit && is_status) ? i_wdata : '0;
    assign status_next = (status_q & ~w1c) | (i_hw_set & STATUS_MASK);
    assign irq_en_next = (wr_hit && is_irq_en) ? (i_wdata & STATUS_MASK) : irq_en_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl_q <= RW_RESET;
        end else begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (ctrl_we[k]) begin
                    ctrl_q[k*DATA_W +: DATA_W] <= i_wdata & RW_MASK[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            status_q <= '0;
            irq_en_q <= '0;
            o_irq    <= 1'b0;
        end else begin
            status_q <= status_next;
            irq_en_q <= irq_en_next;
            o_irq    <= |(status_next & irq_en_next);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_rvalid <= i_read;
            o_err    <= (i_read && !mapped) || (i_write && !wr_ok);
            if (i_read) begin
                o_rdata <= mapped ? rd_mux : '0;
            end
        end
    end

    assign o_ctrl   = ctrl_q;
    assign o_status = status_q;

endmodule
